// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory burst responder:
//   - access_size encodings and the beats_for() beat-count helper
//   - FSM state enum for the burst controller
//   - WORD_BYTES, the byte stride between consecutive burst beats
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mem_state_e;

    // Number of beats in a request; a byte access is always a single beat.
    function automatic logic [4:0] beats_for(input logic [1:0] access_size,
                                             input logic       dm_byte);
        logic [4:0] n;
        if (dm_byte) begin
            n = 5'd1;
        end else begin
            case (access_size)
                SIZE_1:  n = 5'd1;
                SIZE_4:  n = 5'd4;
                SIZE_8:  n = 5'd8;
                SIZE_16: n = 5'd16;
                default: n = 5'd1;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_burst_ctrl
// Request acceptance and burst sequencing for mem_burst_responder.
// Produces one beat command per edge (valid, rw, byte, address) and busy.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   enable, rw, dm_byte     : request valid, 1 = read, single-byte access
//   access_size, address    : burst length code, start byte address
//   do_branch               : abort a burst in progress
//   beat_vld_p0             : a beat is performed at the coming edge
//   beat_rw_p0, beat_byte_p0: direction / byte flag of that beat
//   beat_addr_p0            : byte address of that beat
//   busy                    : burst in progress, new requests ignored
// ---------------------------------------------------------------------------
module mem_burst_ctrl
    import mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic        dm_byte,
    input  logic        do_branch,
    input  logic [1:0]  access_size,
    input  logic [31:0] address,
    output logic        beat_vld_p0,
    output logic        beat_rw_p0,
    output logic        beat_byte_p0,
    output logic [31:0] beat_addr_p0,
    output logic        busy
);

    mem_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  last_q;
    logic [31:0] start_q;
    logic        rw_q;
    logic [4:0]  n_beats;
    logic        start_burst;

    assign n_beats     = beats_for(access_size, dm_byte);
    assign start_burst = (state_q == IDLE) && enable && (n_beats > 5'd1);
    assign busy        = (state_q == BURST);

    // Beat 0 is taken straight from the request inputs; later beats come
    // from the latched start address. Reset suppresses any beat.
    always_comb begin
        beat_vld_p0  = 1'b0;
        beat_rw_p0   = rw;
        beat_byte_p0 = dm_byte;
        beat_addr_p0 = address;
        if (!reset) begin
            if (state_q == IDLE) begin
                beat_vld_p0 = enable;
            end else begin
                beat_vld_p0  = !do_branch;
                beat_rw_p0   = rw_q;
                beat_byte_p0 = 1'b0;
                beat_addr_p0 = start_q + 32'(cnt_q) * 32'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_burst) begin
                        state_q <= BURST;
                        cnt_q   <= 4'd1;
                    end
                end
                BURST: begin
                    if (do_branch || (cnt_q == last_q)) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Burst parameters only matter while in BURST, so they carry no reset.
    always_ff @(posedge clock) begin
        if (start_burst && !reset) begin
            start_q <= {address[31:2], 2'b00};
            last_q  <= 4'(n_beats - 5'd1);
            rw_q    <= rw;
        end
    end

endmodule

// File: rtl/mem_burst_responder.sv
// ---------------------------------------------------------------------------
// mem_burst_responder
// Byte-addressed, big-endian storage responding to word/byte accesses and
// 4/8/16-word bursts. Storage is not cleared by reset.
//
// Parameters: base_addr (byte address of location 0), memory_depth (bytes,
//             multiple of 4)
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   address, data_in        : beat-0 byte address, per-beat write data
//   access_size, rw, enable : burst length code, 1 = read, request valid
//   dm_byte, do_branch      : single-byte access, abort burst
//   wm_bypass, do_wm_bypass : write data override (MEM_WM_BYPASS_EN only)
//   busy, data_out, err     : burst in progress, read data, range error
//
// Optional feature macro: MEM_WM_BYPASS_EN
// ---------------------------------------------------------------------------
module mem_burst_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] base_addr    = 32'h80020000,
    parameter int unsigned memory_depth = 1048576
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_size,
    input  logic        rw,
    input  logic        enable,
    input  logic        dm_byte,
    input  logic        do_branch,
`ifdef MEM_WM_BYPASS_EN
    input  logic [31:0] wm_bypass,
    input  logic        do_wm_bypass,
`endif
    output logic        busy,
    output logic [31:0] data_out,
    output logic        err
);

    localparam int AW = $clog2(memory_depth);

    logic [7:0]    mem [memory_depth];

    logic          beat_vld_p0;
    logic          beat_rw_p0;
    logic          beat_byte_p0;
    logic [31:0]   beat_addr_p0;
    logic [31:0]   a;
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic [31:0]   wdata;

    mem_burst_ctrl u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rw           (rw),
        .dm_byte      (dm_byte),
        .do_branch    (do_branch),
        .access_size  (access_size),
        .address      (address),
        .beat_vld_p0  (beat_vld_p0),
        .beat_rw_p0   (beat_rw_p0),
        .beat_byte_p0 (beat_byte_p0),
        .beat_addr_p0 (beat_addr_p0),
        .busy         (busy)
    );

    // Word accesses are aligned, and memory_depth is a multiple of 4, so a
    // word whose first byte is in range lies entirely in range.
    always_comb begin
        a        = beat_byte_p0 ? beat_addr_p0 : {beat_addr_p0[31:2], 2'b00};
        off      = a - base_addr;
        in_range = (a >= base_addr) && (off < memory_depth);
        idx      = off[AW-1:0];
        if (beat_byte_p0) begin
            rdata = {24'h0, mem[idx]};
        end else begin
            rdata = {mem[{idx[AW-1:2], 2'b00}], mem[{idx[AW-1:2], 2'b01}],
                     mem[{idx[AW-1:2], 2'b10}], mem[{idx[AW-1:2], 2'b11}]};
        end
    end

`ifdef MEM_WM_BYPASS_EN
    assign wdata = do_wm_bypass ? wm_bypass : data_in;
`else
    assign wdata = data_in;
`endif

    // Storage write: out-of-range beats are dropped.
    always_ff @(posedge clock) begin
        if (beat_vld_p0 && !beat_rw_p0 && in_range) begin
            if (beat_byte_p0) begin
                mem[idx] <= wdata[7:0];
            end else begin
                mem[{idx[AW-1:2], 2'b00}] <= wdata[31:24];
                mem[{idx[AW-1:2], 2'b01}] <= wdata[23:16];
                mem[{idx[AW-1:2], 2'b10}] <= wdata[15:8];
                mem[{idx[AW-1:2], 2'b11}] <= wdata[7:0];
            end
        end
    end

    // Output stage: read data and range error, one cycle after the beat edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= 32'h0;
            err      <= 1'b0;
        end else begin
            err <= beat_vld_p0 && !in_range;
            if (beat_vld_p0 && beat_rw_p0) begin
                data_out <= in_range ? rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_responder
// Directed bench: a table of single accesses applied back-to-back, followed
// by hand-written burst, abort, boundary and reset-during-burst sequences.
// ---------------------------------------------------------------------------
module tb_mem_burst_responder;

    localparam logic [31:0] B = 32'h80020000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        dm_byte;
    logic        do_branch;
`ifdef MEM_WM_BYPASS_EN
    logic [31:0] wm_bypass;
    logic        do_wm_bypass;
`endif
    logic        busy;
    logic [31:0] data_out;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_burst_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .access_size  (access_size),
        .rw           (rw),
        .enable       (enable),
        .dm_byte      (dm_byte),
        .do_branch    (do_branch),
`ifdef MEM_WM_BYPASS_EN
        .wm_bypass    (wm_bypass),
        .do_wm_bypass (do_wm_bypass),
`endif
        .busy         (busy),
        .data_out     (data_out),
        .err          (err)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic        byt;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in;
        enable      = 1'b0;
        rw          = 1'b1;
        dm_byte     = 1'b0;
        do_branch   = 1'b0;
        access_size = 2'b00;
        address     = 32'h0;
        data_in     = 32'h0;
`ifdef MEM_WM_BYPASS_EN
        wm_bypass    = 32'h0;
        do_wm_bypass = 1'b0;
`endif
    endtask

    task automatic req(input logic r, input logic [31:0] a, input logic [1:0] sz,
                       input logic byt, input logic [31:0] d);
        enable      = 1'b1;
        rw          = r;
        address     = a;
        access_size = sz;
        dm_byte     = byt;
        data_in     = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, B + 32'h10,     1'b0, 32'h3C01DEAD, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, B + 32'h10,     1'b0, 32'h0,        32'h3C01DEAD, 1'b0};
        vt[2]  = '{1'b0, B + 32'h0,      1'b0, 32'h11223344, 32'h3C01DEAD, 1'b0};
        vt[3]  = '{1'b0, B + 32'h4,      1'b0, 32'h55667788, 32'h3C01DEAD, 1'b0};
        vt[4]  = '{1'b0, B + 32'h8,      1'b0, 32'h99AABBCC, 32'h3C01DEAD, 1'b0};
        vt[5]  = '{1'b0, B + 32'hC,      1'b0, 32'hDDEEFF00, 32'h3C01DEAD, 1'b0};
        vt[6]  = '{1'b0, B + 32'h2,      1'b1, 32'h000000AB, 32'h3C01DEAD, 1'b0};
        vt[7]  = '{1'b1, B + 32'h0,      1'b0, 32'h0,        32'h1122AB44, 1'b0};
        vt[8]  = '{1'b1, B + 32'h2,      1'b1, 32'h0,        32'h000000AB, 1'b0};
        vt[9]  = '{1'b1, B + 32'h7,      1'b1, 32'h0,        32'h00000088, 1'b0};
        vt[10] = '{1'b1, B + 32'h6,      1'b0, 32'h0,        32'h55667788, 1'b0};
        vt[11] = '{1'b1, B - 32'h4,      1'b0, 32'h0,        32'h00000000, 1'b1};
        vt[12] = '{1'b0, B + 32'h100000, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
        vt[13] = '{1'b1, B + 32'h10,     1'b0, 32'h0,        32'h3C01DEAD, 1'b0};
        vt[14] = '{1'b0, B + 32'h10,     1'b0, 32'hA5A5A5A5, 32'h3C01DEAD, 1'b0};
        vt[15] = '{1'b1, B + 32'h10,     1'b0, 32'h0,        32'hA5A5A5A5, 1'b0};
        vt[16] = '{1'b0, B + 32'hFFFFC,  1'b0, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0};
        vt[17] = '{1'b0, B + 32'h54,     1'b0, 32'hEEEE0005, 32'hA5A5A5A5, 1'b0};
        vt[18] = '{1'b0, B + 32'h58,     1'b0, 32'hEEEE0006, 32'hA5A5A5A5, 1'b0};
        vt[19] = '{1'b1, B + 32'hFFFFC,  1'b0, 32'h0,        32'h0BADF00D, 1'b0};

        idle_in();
        reset = 1'b1;
        tick();
        tick();
        chk("reset data_out", data_out, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;

        // Single accesses, one per cycle.
        for (int i = 0; i < 20; i++) begin
            req(vt[i].rw, vt[i].addr, 2'b00, vt[i].byt, vt[i].din);
            tick();
            chk($sformatf("vec%0d data_out", i), data_out, vt[i].exp_dout);
            chk($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vt[i].exp_err});
            chk($sformatf("vec%0d busy", i), {31'h0, busy}, 32'h0);
        end
        idle_in();

        // 4-beat read; a write request held during the burst must be ignored.
        req(1'b1, B, 2'b01, 1'b0, 32'h0);
        tick();
        chk("b4 beat0", data_out, 32'h1122AB44);
        chk("b4 busy0", {31'h0, busy}, 32'h1);
        req(1'b0, B + 32'h10, 2'b00, 1'b0, 32'hFFFFFFFF);
        tick();
        chk("b4 beat1", data_out, 32'h55667788);
        chk("b4 busy1", {31'h0, busy}, 32'h1);
        tick();
        chk("b4 beat2", data_out, 32'h99AABBCC);
        chk("b4 busy2", {31'h0, busy}, 32'h1);
        tick();
        chk("b4 beat3", data_out, 32'hDDEEFF00);
        chk("b4 busy3", {31'h0, busy}, 32'h0);
        idle_in();

        // 8-beat read aborted on beat 3's edge.
        req(1'b1, B, 2'b10, 1'b0, 32'h0);
        tick();
        chk("b8 beat0", data_out, 32'h1122AB44);
        idle_in();
        tick();
        chk("b8 beat1", data_out, 32'h55667788);
        tick();
        chk("b8 beat2", data_out, 32'h99AABBCC);
        chk("b8 busy2", {31'h0, busy}, 32'h1);
        do_branch = 1'b1;
        tick();
        chk("abort data_out held", data_out, 32'h99AABBCC);
        chk("abort busy", {31'h0, busy}, 32'h0);
        // do_branch while idle does not block acceptance.
        req(1'b1, B + 32'h10, 2'b00, 1'b0, 32'h0);
        tick();
        chk("post-abort read", data_out, 32'hA5A5A5A5);
        chk("post-abort busy", {31'h0, busy}, 32'h0);
        idle_in();

        // 4-beat read straddling the end of storage.
        req(1'b1, B + 32'hFFFFC, 2'b01, 1'b0, 32'h0);
        tick();
        chk("edge beat0", data_out, 32'h0BADF00D);
        chk("edge err0", {31'h0, err}, 32'h0);
        idle_in();
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("edge beat%0d", k), data_out, 32'h0);
            chk($sformatf("edge err%0d", k), {31'h0, err}, 32'h1);
        end
        chk("edge busy end", {31'h0, busy}, 32'h0);
        tick();
        chk("edge err clears", {31'h0, err}, 32'h0);

        // 16-beat write interrupted by reset at beat 5.
        req(1'b1, B + 32'h10, 2'b00, 1'b0, 32'h0);
        tick();
        chk("pre-wr read", data_out, 32'hA5A5A5A5);
        req(1'b0, B + 32'h40, 2'b11, 1'b0, 32'h10000000);
        tick();
        chk("wr16 busy", {31'h0, busy}, 32'h1);
        enable = 1'b0;
        for (int k = 1; k < 5; k++) begin
            data_in = 32'h10000000 + 32'(k);
            tick();
        end
        data_in = 32'h10000005;
        reset   = 1'b1;
        tick();
        chk("rst-burst data_out", data_out, 32'h0);
        chk("rst-burst busy", {31'h0, busy}, 32'h0);
        chk("rst-burst err", {31'h0, err}, 32'h0);
        reset = 1'b0;
        idle_in();
        for (int k = 0; k < 7; k++) begin
            logic [31:0] expv;
            expv = (k < 5) ? (32'h10000000 + 32'(k)) : (32'hEEEE0000 + 32'(k));
            req(1'b1, B + 32'h40 + 32'(4 * k), 2'b00, 1'b0, 32'h0);
            tick();
            chk($sformatf("wr16 word%0d", k), data_out, expv);
        end
        idle_in();

`ifdef MEM_WM_BYPASS_EN
        req(1'b0, B + 32'h80, 2'b00, 1'b0, 32'h11111111);
        wm_bypass    = 32'hCAFEF00D;
        do_wm_bypass = 1'b1;
        tick();
        req(1'b0, B + 32'h84, 2'b00, 1'b1, 32'h000000EE);
        tick();
        do_wm_bypass = 1'b0;
        req(1'b1, B + 32'h80, 2'b00, 1'b0, 32'h0);
        tick();
        chk("bypass word", data_out, 32'hCAFEF00D);
        req(1'b1, B + 32'h84, 2'b00, 1'b1, 32'h0);
        tick();
        chk("bypass byte", data_out, 32'h0000000D);
        idle_in();
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
